sobel_edge_detector: RTL and testbench
======================================

Name: sobel_edge_detector

Overview:
Downstream consumer of the grayscaled 3x3 pixel-matrix stream produced by the colorspace/matrix stage. Computes the Sobel gradient magnitude |Gx|+|Gy| for each valid matrix in a fixed 3-stage pipeline, then saturates and thresholds it. Emits one edge pixel per input matrix, tagged with the matrix's column/row. Also keeps a per-frame edge-pixel count, latched at the last frame position.

Parameters:
P_FRAME_COLUMNS, 640, frame width in pixels
P_FRAME_ROWS, 480, frame height in pixels
P_SUBPIXEL_DEPTH, 8, grayscale pixel width
P_THRESHOLD, 64, edge decision: saturated magnitude >= P_THRESHOLD
P_BINARY_OUTPUT, 0, 0: O_PIXEL = saturated magnitude; 1: O_PIXEL = all-ones on edge, else 0
P_LAST_COLUMN, P_FRAME_COLUMNS-1, column of the final matrix in a frame
P_LAST_ROW, P_FRAME_ROWS-1, row of the final matrix in a frame
P_FRAME_COLUMN_BITS, $clog2(P_FRAME_COLUMNS), derived
P_FRAME_ROW_BITS, $clog2(P_FRAME_ROWS), derived
P_COUNT_BITS, $clog2(P_FRAME_COLUMNS*P_FRAME_ROWS+1), derived

Ports:
I_CLK  in  1  clock
I_RESET  in  1  synchronous, active-high reset
I_PIXEL_COLUMN  in  P_FRAME_COLUMN_BITS  column tag of the input matrix
I_PIXEL_ROW  in  P_FRAME_ROW_BITS  row tag of the input matrix
I_PIXEL_MATRIX  in  8*P_SUBPIXEL_DEPTH  {tl,t,tr,ml,mr,bl,b,br}; tl in the MSBs; no centre pixel
I_PIXEL_MATRIX_READY  in  1  input valid qualifier
O_PIXEL_COLUMN  out  P_FRAME_COLUMN_BITS  column tag of the output pixel
O_PIXEL_ROW  out  P_FRAME_ROW_BITS  row tag of the output pixel
O_PIXEL  out  P_SUBPIXEL_DEPTH  edge pixel
O_EDGE  out  1  1 if saturated magnitude >= P_THRESHOLD
O_PIXEL_READY  out  1  output valid
O_FRAME_DONE  out  1  one-cycle pulse when the last frame pixel is output
O_FRAME_EDGE_COUNT  out  P_COUNT_BITS  edge count of the most recently completed frame

Behaviour:
- Reset: every output is 0. All stage valids, tag registers and the running counter are cleared. A reset mid-pipeline discards in-flight data, and no O_PIXEL_READY is asserted for that data.
- No backpressure. A new matrix is accepted every cycle in which I_PIXEL_MATRIX_READY=1. Bubbles propagate as valid=0.
- Latency: a matrix sampled at edge N appears at outputs after edge N+3, with O_PIXEL_READY=1.
- Column/row tags travel with their data through every stage.
- S1: register unsigned sums, each P_SUBPIXEL_DEPTH+2 bits:
  - xp = tr + 2*mr + br
  - xn = tl + 2*ml + bl
  - yp = bl + 2*b + br
  - yn = tl + 2*t + tr
- S2: register ax = |xp - xn| and ay = |yp - yn|. Use a compare-then-subtract so no signed width is needed; each is P_SUBPIXEL_DEPTH+2 bits.
- S3, magnitude:
  - m = ax + ay, P_SUBPIXEL_DEPTH+3 bits.
  - sat = all-ones if m > 2^P_SUBPIXEL_DEPTH - 1, else m.
  - O_EDGE = (sat >= P_THRESHOLD).
  - O_PIXEL per P_BINARY_OUTPUT.
- S3, frame statistics:
  - The running counter increments when an S3 output is valid and is an edge.
  - When the S3 output is valid with tag == (P_LAST_COLUMN, P_LAST_ROW):
    - O_FRAME_EDGE_COUNT <= counter + edge.
    - O_FRAME_DONE = 1 for that cycle.
    - The counter is cleared to 0 (the clear has priority over the increment).
- Outputs hold their values while O_PIXEL_READY=0. O_FRAME_EDGE_COUNT holds until the next frame completes.
- The counter saturates at its maximum value and does not wrap.

Decomposition:
- A shared header/package holds:
  - the matrix field index constants (TL..BR slice offsets, shared with the matrix producer);
  - the derived widths P_SUM_BITS = P_SUBPIXEL_DEPTH+2 and P_MAG_BITS = P_SUBPIXEL_DEPTH+3.
- One sub-module, sobel_magnitude3: the S1–S3 datapath with its valid/tag pipe and a magnitude output.
- The top level adds saturation, threshold, output registers and frame statistics.

Test Plan:
- All eight pixels = 100, ready=1 at edge N -> after edge N+3: O_PIXEL_READY=1, O_PIXEL=0, O_EDGE=0.
- tl=ml=bl=0, tr=mr=br=255, t=b=0 -> Gx=1020, Gy=0 -> O_PIXEL=255, O_EDGE=1.
- tr=10, all others 0 -> |Gx|=10, |Gy|=10 -> O_PIXEL=20, O_EDGE=0. Repeat with P_BINARY_OUTPUT=1: O_PIXEL=0. With tl=200, all others 0 -> magnitude 400 saturates -> O_PIXEL=255 (or 255 in binary mode).
- Stream with tags, pattern ready 1,0,1,1 -> O_PIXEL_READY follows 1,0,1,1 shifted by 3 cycles, and the tags match the inputs exactly.
- P_FRAME_COLUMNS=4, P_FRAME_ROWS=3, 12 matrices with 5 edges, the last one an edge -> O_FRAME_DONE pulses once with the tag (3,2), O_FRAME_EDGE_COUNT=5. The next frame's count starts from 0.
- Assert I_RESET while 2 valid matrices are in flight -> no O_PIXEL_READY afterwards, all outputs are 0, and the next frame's count excludes the discarded data.

Source files
------------

// File: rtl/sobel_edge_detector_pkg.sv
// Shared constants for the Sobel edge stage: matrix field positions and derived datapath widths.
package sobel_edge_detector_pkg;

   // Field index within the 8-pixel matrix word; field i occupies bits [i*depth +: depth]
   localparam int unsigned MATRIX_TL = 7;
   localparam int unsigned MATRIX_T  = 6;
   localparam int unsigned MATRIX_TR = 5;
   localparam int unsigned MATRIX_ML = 4;
   localparam int unsigned MATRIX_MR = 3;
   localparam int unsigned MATRIX_BL = 2;
   localparam int unsigned MATRIX_B  = 1;
   localparam int unsigned MATRIX_BR = 0;

   localparam int unsigned SUM_EXTRA_BITS = 2;
   localparam int unsigned MAG_EXTRA_BITS = 3;

   function automatic int unsigned sum_bits(input int unsigned depth);
      return depth + SUM_EXTRA_BITS;
   endfunction

   function automatic int unsigned mag_bits(input int unsigned depth);
      return depth + MAG_EXTRA_BITS;
   endfunction

endpackage

// File: rtl/sobel_magnitude3.sv
// Three-stage |Gx|+|Gy| datapath: weighted sums, absolute differences, magnitude.
module sobel_magnitude3
   import sobel_edge_detector_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned COL_BITS = 10,
   parameter int unsigned ROW_BITS = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [COL_BITS-1:0]        column,
   input  logic [ROW_BITS-1:0]        row,
   input  logic [8*DEPTH-1:0]         matrix,
   input  logic                       valid,
   output logic [COL_BITS-1:0]        mag_column,
   output logic [ROW_BITS-1:0]        mag_row,
   output logic [mag_bits(DEPTH)-1:0] mag,
   output logic                       mag_valid
);

   localparam int unsigned SUM_BITS = sum_bits(DEPTH);
   localparam int unsigned MAG_BITS = mag_bits(DEPTH);

   logic [DEPTH-1:0] tl, t, tr, ml, mr, bl, b, br;

   assign tl = matrix[MATRIX_TL*DEPTH +: DEPTH];
   assign t  = matrix[MATRIX_T*DEPTH  +: DEPTH];
   assign tr = matrix[MATRIX_TR*DEPTH +: DEPTH];
   assign ml = matrix[MATRIX_ML*DEPTH +: DEPTH];
   assign mr = matrix[MATRIX_MR*DEPTH +: DEPTH];
   assign bl = matrix[MATRIX_BL*DEPTH +: DEPTH];
   assign b  = matrix[MATRIX_B*DEPTH  +: DEPTH];
   assign br = matrix[MATRIX_BR*DEPTH +: DEPTH];

   logic                s1_valid, s2_valid;
   logic [COL_BITS-1:0] s1_column, s2_column;
   logic [ROW_BITS-1:0] s1_row, s2_row;
   logic [SUM_BITS-1:0] xp, xn, yp, yn;
   logic [SUM_BITS-1:0] ax, ay;

   // Positive and negative kernel halves kept unsigned; the sign is resolved in stage 2
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_column  <= '0;
         s1_row     <= '0;
         xp         <= '0;
         xn         <= '0;
         yp         <= '0;
         yn         <= '0;
         s2_valid   <= 1'b0;
         s2_column  <= '0;
         s2_row     <= '0;
         ax         <= '0;
         ay         <= '0;
         mag_valid  <= 1'b0;
         mag_column <= '0;
         mag_row    <= '0;
         mag        <= '0;
      end else begin
         s1_valid   <= valid;
         s1_column  <= column;
         s1_row     <= row;
         xp         <= SUM_BITS'(tr) + SUM_BITS'({mr, 1'b0}) + SUM_BITS'(br);
         xn         <= SUM_BITS'(tl) + SUM_BITS'({ml, 1'b0}) + SUM_BITS'(bl);
         yp         <= SUM_BITS'(bl) + SUM_BITS'({b, 1'b0}) + SUM_BITS'(br);
         yn         <= SUM_BITS'(tl) + SUM_BITS'({t, 1'b0}) + SUM_BITS'(tr);

         s2_valid   <= s1_valid;
         s2_column  <= s1_column;
         s2_row     <= s1_row;
         ax         <= (xp >= xn) ? (xp - xn) : (xn - xp);
         ay         <= (yp >= yn) ? (yp - yn) : (yn - yp);

         mag_valid  <= s2_valid;
         mag_column <= s2_column;
         mag_row    <= s2_row;
         mag        <= MAG_BITS'(ax) + MAG_BITS'(ay);
      end
   end

endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel edge stage: saturates and thresholds the gradient magnitude and keeps per-frame edge counts.
module sobel_edge_detector
   import sobel_edge_detector_pkg::*;
#(
   parameter int unsigned P_FRAME_COLUMNS     = 640,
   parameter int unsigned P_FRAME_ROWS        = 480,
   parameter int unsigned P_SUBPIXEL_DEPTH    = 8,
   parameter int unsigned P_THRESHOLD         = 64,
   parameter int unsigned P_BINARY_OUTPUT     = 0,
   parameter int unsigned P_LAST_COLUMN       = P_FRAME_COLUMNS - 1,
   parameter int unsigned P_LAST_ROW          = P_FRAME_ROWS - 1,
   parameter int unsigned P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
   parameter int unsigned P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
   parameter int unsigned P_COUNT_BITS        = $clog2(P_FRAME_COLUMNS * P_FRAME_ROWS + 1)
) (
   input  logic                           I_CLK,
   input  logic                           I_RESET,
   input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
   input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
   input  logic [8*P_SUBPIXEL_DEPTH-1:0]  I_PIXEL_MATRIX,
   input  logic                           I_PIXEL_MATRIX_READY,
   output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
   output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
   output logic [P_SUBPIXEL_DEPTH-1:0]    O_PIXEL,
   output logic                           O_EDGE,
   output logic                           O_PIXEL_READY,
   output logic                           O_FRAME_DONE,
   output logic [P_COUNT_BITS-1:0]        O_FRAME_EDGE_COUNT
);

   localparam int unsigned MAG_BITS = mag_bits(P_SUBPIXEL_DEPTH);

   logic [MAG_BITS-1:0]            mag;
   logic                           mag_valid;
   logic [P_FRAME_COLUMN_BITS-1:0] mag_column;
   logic [P_FRAME_ROW_BITS-1:0]    mag_row;

   sobel_magnitude3 #(
      .DEPTH    (P_SUBPIXEL_DEPTH),
      .COL_BITS (P_FRAME_COLUMN_BITS),
      .ROW_BITS (P_FRAME_ROW_BITS)
   ) u_magnitude (
      .clk        (I_CLK),
      .reset      (I_RESET),
      .column     (I_PIXEL_COLUMN),
      .row        (I_PIXEL_ROW),
      .matrix     (I_PIXEL_MATRIX),
      .valid      (I_PIXEL_MATRIX_READY),
      .mag_column (mag_column),
      .mag_row    (mag_row),
      .mag        (mag),
      .mag_valid  (mag_valid)
   );

   logic [P_SUBPIXEL_DEPTH-1:0] sat_c;
   logic [P_SUBPIXEL_DEPTH-1:0] pixel_c;
   logic                        is_edge_c;
   logic                        last_c;
   logic [P_COUNT_BITS-1:0]     count;
   logic [P_COUNT_BITS-1:0]     count_next_c;

   // Saturation, threshold and the counter's saturating increment
   always_comb begin
      sat_c        = (|mag[MAG_BITS-1:P_SUBPIXEL_DEPTH]) ? '1 : mag[P_SUBPIXEL_DEPTH-1:0];
      is_edge_c    = MAG_BITS'(sat_c) >= MAG_BITS'(P_THRESHOLD);
      pixel_c      = sat_c;
      if (P_BINARY_OUTPUT != 0) begin
         pixel_c = is_edge_c ? '1 : '0;
      end
      last_c       = (mag_column == P_FRAME_COLUMN_BITS'(P_LAST_COLUMN)) &&
                     (mag_row == P_FRAME_ROW_BITS'(P_LAST_ROW));
      count_next_c = count;
      if (is_edge_c && (count != '1)) begin
         count_next_c = count + P_COUNT_BITS'(1);
      end
   end

   // Output registers hold between valid pixels; the frame clear wins over the increment
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         O_PIXEL_COLUMN     <= '0;
         O_PIXEL_ROW        <= '0;
         O_PIXEL            <= '0;
         O_EDGE             <= 1'b0;
         O_PIXEL_READY      <= 1'b0;
         O_FRAME_DONE       <= 1'b0;
         O_FRAME_EDGE_COUNT <= '0;
         count              <= '0;
      end else begin
         O_PIXEL_READY <= mag_valid;
         O_FRAME_DONE  <= mag_valid && last_c;
         if (mag_valid) begin
            O_PIXEL_COLUMN <= mag_column;
            O_PIXEL_ROW    <= mag_row;
            O_PIXEL        <= pixel_c;
            O_EDGE         <= is_edge_c;
            if (last_c) begin
               O_FRAME_EDGE_COUNT <= count_next_c;
               count              <= '0;
            end else begin
               count <= count_next_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Scoreboard bench for sobel_edge_detector: magnitude-mode and binary-mode instances on a 4x3 frame.
module tb_sobel_edge_detector;

   localparam int unsigned COLS = 4;
   localparam int unsigned ROWS = 3;
   localparam int unsigned D    = 8;
   localparam int unsigned CB   = 2;
   localparam int unsigned RB   = 2;
   localparam int unsigned NB   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [CB-1:0] col_in;
   logic [RB-1:0] row_in;
   logic [8*D-1:0] mat_in;
   logic          vin;

   logic [CB-1:0] o_col, b_col;
   logic [RB-1:0] o_row, b_row;
   logic [D-1:0]  o_pix, b_pix;
   logic          o_edge, b_edge, o_rdy, b_rdy, o_done, b_done;
   logic [NB-1:0] o_cnt, b_cnt;

   always #5 clk = ~clk;

   sobel_edge_detector #(
      .P_FRAME_COLUMNS (COLS), .P_FRAME_ROWS (ROWS), .P_SUBPIXEL_DEPTH (D),
      .P_THRESHOLD (64), .P_BINARY_OUTPUT (0)
   ) dut (
      .I_CLK (clk), .I_RESET (rst), .I_PIXEL_COLUMN (col_in), .I_PIXEL_ROW (row_in),
      .I_PIXEL_MATRIX (mat_in), .I_PIXEL_MATRIX_READY (vin),
      .O_PIXEL_COLUMN (o_col), .O_PIXEL_ROW (o_row), .O_PIXEL (o_pix), .O_EDGE (o_edge),
      .O_PIXEL_READY (o_rdy), .O_FRAME_DONE (o_done), .O_FRAME_EDGE_COUNT (o_cnt)
   );

   sobel_edge_detector #(
      .P_FRAME_COLUMNS (COLS), .P_FRAME_ROWS (ROWS), .P_SUBPIXEL_DEPTH (D),
      .P_THRESHOLD (64), .P_BINARY_OUTPUT (1)
   ) dut_bin (
      .I_CLK (clk), .I_RESET (rst), .I_PIXEL_COLUMN (col_in), .I_PIXEL_ROW (row_in),
      .I_PIXEL_MATRIX (mat_in), .I_PIXEL_MATRIX_READY (vin),
      .O_PIXEL_COLUMN (b_col), .O_PIXEL_ROW (b_row), .O_PIXEL (b_pix), .O_EDGE (b_edge),
      .O_PIXEL_READY (b_rdy), .O_FRAME_DONE (b_done), .O_FRAME_EDGE_COUNT (b_cnt)
   );

   typedef struct {
      int unsigned col;
      int unsigned row;
      int unsigned pix;
      int unsigned pixb;
      int unsigned edg;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   int          checks   = 0;
   int          failures = 0;
   bit          mon_en   = 1'b0;
   logic [3:0]  hist;
   int unsigned run_cnt, exp_cnt, exp_done, exp_col, exp_row, exp_pix, exp_pixb, exp_edge;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pk(input logic [7:0] tl, t, tr, ml, mr, bl, b, br);
      return {tl, t, tr, ml, mr, bl, b, br};
   endfunction

   // Reference: Sobel kernels written out directly as signed integers
   function automatic exp_t model(input int unsigned c, r, input logic [63:0] m);
      exp_t e;
      int   p[8];
      int   gx, gy, mag, sat;
      for (int i = 0; i < 8; i++) p[i] = int'(m[63-8*i -: 8]);
      gx  = (p[2] + 2*p[4] + p[7]) - (p[0] + 2*p[3] + p[5]);
      gy  = (p[5] + 2*p[6] + p[7]) - (p[0] + 2*p[1] + p[2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      sat = (mag > 255) ? 255 : mag;
      e.col  = c;
      e.row  = r;
      e.pix  = int'(sat);
      e.edg  = (sat >= 64) ? 1 : 0;
      e.pixb = (sat >= 64) ? 255 : 0;
      return e;
   endfunction

   task automatic clear_model();
      q.delete();
      run_cnt = 0; exp_cnt = 0; exp_done = 0; exp_col = 0; exp_row = 0;
      exp_pix = 0; exp_pixb = 0; exp_edge = 0;
   endtask

   task automatic drive(input bit v, input int unsigned c, r, input logic [63:0] m);
      @(posedge clk);
      #1;
      vin    = v;
      col_in = CB'(c);
      row_in = RB'(r);
      mat_in = m;
      if (v) q.push_back(model(c, r, m));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 64'h0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst    = 1'b1;
      vin    = 1'b0;
      clear_model();
      repeat (n) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   // Expected valid pattern: input valid delayed by three edges
   always @(posedge clk) begin
      if (rst) hist <= '0;
      else     hist <= {hist[2:0], vin};
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("ready", o_rdy, hist[3]);
         chk("bin_ready", b_rdy, hist[3]);
         exp_done = 0;
         if (o_rdy === 1'b1) begin
            if (q.size() == 0) begin
               chk("underflow", 1, 0);
            end else begin
               cur      = q.pop_front();
               exp_col  = cur.col;
               exp_row  = cur.row;
               exp_pix  = cur.pix;
               exp_pixb = cur.pixb;
               exp_edge = cur.edg;
               if (cur.col == COLS-1 && cur.row == ROWS-1) begin
                  exp_cnt  = run_cnt + cur.edg;
                  run_cnt  = 0;
                  exp_done = 1;
               end else begin
                  run_cnt = run_cnt + cur.edg;
               end
            end
         end
         chk("col", o_col, exp_col);
         chk("row", o_row, exp_row);
         chk("pixel", o_pix, exp_pix);
         chk("edge", o_edge, exp_edge);
         chk("frame_done", o_done, exp_done);
         chk("frame_count", o_cnt, exp_cnt);
         chk("bin_col", b_col, exp_col);
         chk("bin_row", b_row, exp_row);
         chk("bin_pixel", b_pix, exp_pixb);
         chk("bin_edge", b_edge, exp_edge);
         chk("bin_frame_done", b_done, exp_done);
         chk("bin_frame_count", b_cnt, exp_cnt);
      end
   end

   logic [63:0] v_flat, v_gx, v_small, v_sat;
   int          edge_pos[5] = '{1, 4, 6, 9, 11};
   int          drained;

   initial begin
      rst = 1'b1; vin = 1'b0; col_in = '0; row_in = '0; mat_in = '0;
      clear_model();
      v_flat  = {8{8'd100}};
      v_gx    = pk(8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255);
      v_small = pk(8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      v_sat   = pk(8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      do_reset(3);
      idle(2);

      // Directed magnitudes: flat, strong Gx, small, saturating
      drive(1'b1, 0, 0, v_flat);
      drive(1'b1, 1, 0, v_gx);
      drive(1'b1, 2, 0, v_small);
      drive(1'b1, 3, 1, v_sat);
      // Valid pattern 1,0,1,1 with distinct tags
      drive(1'b1, 1, 1, v_small);
      drive(1'b0, 2, 2, v_gx);
      drive(1'b1, 2, 1, v_gx);
      drive(1'b1, 0, 2, v_flat);
      idle(6);

      // Reset with two edge matrices in flight; their edges must not reach the next count
      drive(1'b1, 0, 0, v_gx);
      drive(1'b1, 1, 0, v_gx);
      do_reset(2);
      idle(6);

      // Frame of 12 with 5 edges, last one an edge, one bubble mid-frame
      for (int i = 0; i < COLS*ROWS; i++) begin
         bit is_e;
         is_e = 1'b0;
         foreach (edge_pos[k]) if (edge_pos[k] == i) is_e = 1'b1;
         if (i == 5) drive(1'b0, 0, 0, v_gx);
         drive(1'b1, i % COLS, i / COLS, is_e ? ((i % 2) ? v_gx : v_sat)
                                              : ((i % 2) ? v_flat : v_small));
      end
      idle(6);
      chk("frame1_count_is_5", o_cnt, 5);

      // Second frame with random pixels and random bubbles; count restarts from 0
      for (int i = 0; i < COLS*ROWS; i++) begin
         if ($urandom_range(0, 3) == 0) drive(1'b0, 0, 0, 64'h0);
         drive(1'b1, i % COLS, i / COLS, {$urandom, $urandom});
      end
      // Random tags and valids, exercising frame completion at arbitrary points
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1),
               {$urandom, $urandom});
      end

      drained = 0;
      for (int i = 0; i < 10 && !drained; i++) begin
         drive(1'b0, 0, 0, 64'h0);
         if (q.size() == 0) drained = 1;
      end
      idle(2);
      chk("drain", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
